hex_inverter_test_sequencer: RTL and testbench
==============================================

// Module: hex_inverter_test_sequencer
// PURPOSE
//  Synchronous controller that sequences a 6-gate inverter bank (sn74ls04-class hex inverter) through
//  a fixed stimulus pattern list, waits a programmable settle time, checks each output and reports
//  pass/fail. Sits beside the DUT in the device-model regression benches as the self-checking stimulus engine.
// PARAMETERS
//  N_GATES   6   number of inverter channels driven and checked (1..8)
//  SETTLE    4   clock cycles between driving a pattern and sampling y (1..255)
// PORTS
//  clk         in   1        rising-edge clock, the single clock of the block
//  rst         in   1        synchronous reset, active-high
//  start       in   1        one-cycle pulse; starts a run when idle
//  a           out  N_GATES  stimulus driven to the inverter inputs
//  y           in   N_GATES  inverter outputs sampled at check time
//  busy        out  1        high from the cycle after start until done asserts
//  done        out  1        one-cycle pulse when a run finishes
//  pass        out  1        valid while not busy: last run had no mismatch
//  fail_mask   out  N_GATES  sticky per-channel mismatch bits for the current/last run
//  pat_idx     out  4        index of the pattern currently applied
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, a=0, busy=0, done=0, pass=0, fail_mask=0, pat_idx=0, settle cnt=0.
//  - Pattern list (N_GATES bits, index 0..N_GATES+1): 0 all-zero, 1 all-one, 2..N_GATES+1 walking
//    one (1<<(idx-2)). Last index LAST = N_GATES+1.
//  - FSM IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | DONE) -> IDLE.
//    IDLE:   start=1 -> pat_idx=0, fail_mask=0, pass=0, busy=1, go DRIVE. start ignored elsewhere.
//    DRIVE:  a <= pattern[pat_idx]; cnt <= SETTLE-1; go SETTLE (1 cycle).
//    SETTLE: cnt decrements each cycle; at cnt==0 go CHECK. Total DRIVE-to-CHECK = SETTLE+1 cycles.
//    CHECK:  fail_mask <= fail_mask | (y ^ ~a); if pat_idx==LAST go DONE else pat_idx+1, go DRIVE.
//    DONE:   done=1 for exactly one cycle, busy=0, pass = (fail_mask==0 incl. this CHECK); a holds the
//            last pattern; go IDLE.
//  - Run length = (LAST+1)*(SETTLE+2)+1 cycles from start to done pulse.
//  - Compare uses only N_GATES bits; X/Z on y counts as mismatch (=== semantics in CHECK).
//  - start coincident with rst: rst wins, no run. rst mid-run: abort immediately to reset values, no done.
//  - start in the same cycle as done: ignored (FSM is in DONE, not IDLE).
// CONFIGURATION
//  HEX_INV_SEQ_STOP_ON_FAIL_EN defined: CHECK with a nonzero new mismatch goes straight to DONE;
//    pat_idx freezes at the failing pattern, a holds it for debug, pass=0.
//  Undefined: all patterns always run; fail_mask accumulates across the full list.
// STRUCTURE
//  - Shared include hex_inv_seq_defs.vh: state encodings (IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4,
//    3-bit), pattern-index width, pattern-count formula.
//  - One sub-module hex_inv_seq_patrom: combinational idx -> pattern decode, parameterised by N_GATES.
// TESTING (bench instantiates sequencer + sn74ls04 x6, SETTLE=4, timescale 1ns/100ps, $monitor trace)
//  1 rst=1 2 cycles with start=1 -> a=0, busy=0, done=0, pass=0, fail_mask=0.
//  2 start pulse, healthy DUT -> a steps 00,3F,01,02,04,08,10,20; done at cycle 49; pass=1, fail_mask=00.
//  3 force y[2] stuck-0 -> fail_mask=04, pass=0; with STOP_ON_FAIL_EN done after pattern 0, pat_idx=0.
//  4 tie y=a (non-inverting fault) -> fail_mask=3F, pass=0.
//  5 rst asserted during pattern 3 SETTLE -> next cycle all outputs at reset values, no done pulse.
//  6 start held high through whole run -> exactly one run, single done pulse; second run only after IDLE.

Source files
------------

// File: rtl/hex_inverter_test_sequencer_pkg.sv
// Shared definitions for the hex inverter test sequencer.
//   state_e    : FSM state encoding (IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4)
//   PatIdxW    : width of the pattern index
//   pat_count(): number of patterns for a given gate count (all-zero, all-one, walking ones)
package hex_inverter_test_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrive  = 3'd1,
    StSettle = 3'd2,
    StCheck  = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam int unsigned PatIdxW = 4;

  function automatic int unsigned pat_count(input int unsigned n_gates);
    return n_gates + 2;
  endfunction

endpackage

// File: rtl/hex_inverter_test_sequencer_patrom.sv
// Combinational pattern decode for the hex inverter test sequencer.
//   idx     in   PatIdxW   pattern index
//   pattern out  N_GATES   0 -> all-zero, 1 -> all-one, 2..N_GATES+1 -> walking one
// Out-of-range indices decode to all-zero.
module hex_inverter_test_sequencer_patrom
  import hex_inverter_test_sequencer_pkg::*;
#(
  parameter int unsigned N_GATES = 6
) (
  input  logic [PatIdxW-1:0] idx,
  output logic [N_GATES-1:0] pattern
);

  always_comb begin
    pattern = '0;
    if (idx == PatIdxW'(1)) begin
      pattern = '1;
    end else begin
      for (int unsigned i = 0; i < N_GATES; i++) begin
        if (32'(idx) == i + 32'd2) pattern[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_inverter_test_sequencer.sv
// Self-checking stimulus engine for an N_GATES-channel inverter bank. Steps through the
// pattern list, waits SETTLE cycles after each drive, compares y against ~a and reports
// a sticky per-channel fail mask plus a pass flag when the run ends.
//   clk, rst    in   clock, synchronous active-high reset
//   start       in   one-cycle pulse, honoured only when idle
//   a           out  stimulus to the inverter inputs
//   y           in   inverter outputs
//   busy        out  run in progress (cleared together with the done pulse)
//   done        out  one-cycle end-of-run pulse
//   pass        out  last run had no mismatch (valid while not busy)
//   fail_mask   out  sticky per-channel mismatch bits
//   pat_idx     out  index of the applied pattern
// Build option: HEX_INV_SEQ_STOP_ON_FAIL_EN ends the run at the first failing pattern,
// leaving pat_idx and a on that pattern.
module hex_inverter_test_sequencer
  import hex_inverter_test_sequencer_pkg::*;
#(
  parameter int unsigned N_GATES = 6,
  parameter int unsigned SETTLE  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_GATES-1:0] a,
  input  logic [N_GATES-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] fail_mask,
  output logic [3:0]         pat_idx
);

  localparam logic [PatIdxW-1:0] Last       = PatIdxW'(pat_count(N_GATES) - 1);
  localparam logic [7:0]         SettleInit = 8'(SETTLE - 1);

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [N_GATES-1:0] pattern;
  logic [N_GATES-1:0] mism;
  logic [N_GATES-1:0] mask_nxt;
  logic               stop;

  hex_inverter_test_sequencer_patrom #(
    .N_GATES (N_GATES)
  ) u_patrom (
    .idx     (pat_idx),
    .pattern (pattern)
  );

  // Case-equality so an X/Z on y is flagged as a mismatch rather than propagating.
  always_comb begin
    mism = '0;
    for (int unsigned i = 0; i < N_GATES; i++) begin
      mism[i] = (y[i] === ~a[i]) ? 1'b0 : 1'b1;
    end
    mask_nxt = fail_mask | mism;
`ifdef HEX_INV_SEQ_STOP_ON_FAIL_EN
    stop = |mism;
`else
    stop = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      pat_idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pat_idx   <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StDrive;
          end
        end
        StDrive: begin
          a       <= pattern;
          cnt_q   <= SettleInit;
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == 8'd0) state_q <= StCheck;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        StCheck: begin
          fail_mask <= mask_nxt;
          if (pat_idx == Last || stop) begin
            // done/busy/pass change together so pass is valid the moment busy drops.
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (mask_nxt == '0);
            state_q <= StDone;
          end else begin
            pat_idx <= pat_idx + 4'd1;
            state_q <= StDrive;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_inverter_test_sequencer.sv
`timescale 1ns / 100ps
module tb_hex_inverter_test_sequencer;

  localparam int unsigned NG     = 6;
  localparam int unsigned STL    = 4;
  localparam int unsigned PER    = STL + 2;       // cycles per pattern
  localparam int unsigned RUNLEN = (NG + 2) * PER; // start-sampling edge to done-visible edge

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] a, y, fail_mask;
  logic       busy, done, pass;
  logic [3:0] pat_idx;
  int         fault = 0;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned cyc;
    logic        pass;
    logic [5:0]  mask;
    logic [3:0]  idx;
    logic [5:0]  a;
  } exp_t;
  exp_t sb[$];

  hex_inverter_test_sequencer #(
    .N_GATES (NG),
    .SETTLE  (STL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .pat_idx   (pat_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inverter bank model: 0 healthy, 1 y[2] stuck-0, 2 non-inverting (y=a).
  always_comb begin
    case (fault)
      0:       y = ~a;
      1:       y = ~a & 6'h3B;
      default: y = a;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] pat(input int k);
    logic [5:0] one;
    one = 6'h01;
    if (k == 0) return 6'h00;
    if (k == 1) return 6'h3F;
    return one << (k - 2);
  endfunction

  // Wait (bounded) until the negedge where cyc has reached t.
  task automatic wait_cyc(input int unsigned t);
    int g;
    g = 0;
    while (cyc < t && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pulse (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass", pass, e.pass);
        check("fail_mask", fail_mask, e.mask);
        check("pat_idx_at_done", pat_idx, e.idx);
        check("a_at_done", a, e.a);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic do_run(input int f, input logic p, input logic [5:0] m, input logic [3:0] idx,
                        input logic [5:0] la, input int unsigned len, input bit trace);
    int unsigned s;
    fault = f;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    sb.push_back('{cyc: s + len, pass: p, mask: m, idx: idx, a: la});
    if (trace) begin
      for (int k = 0; k < int'(NG) + 2; k++) begin
        wait_cyc(s + PER * k + 3); // middle of the settle window of pattern k
        check($sformatf("trace_a_%0d", k), a, pat(k));
        check($sformatf("trace_idx_%0d", k), pat_idx, k);
        check($sformatf("trace_busy_%0d", k), busy, 1);
      end
    end
    wait_cyc(s + len + 2);
    check("done_seen", sb.size(), 0);
  endtask

  initial begin
    int unsigned s;

    // Reset with start held: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mask", fail_mask, 0);
    check("rst_idx", pat_idx, 0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst", busy, 0);

    // Healthy bank, full pattern trace.
    do_run(0, 1'b1, 6'h00, 4'd7, 6'h20, RUNLEN, 1'b1);

`ifdef HEX_INV_SEQ_STOP_ON_FAIL_EN
    do_run(1, 1'b0, 6'h04, 4'd0, 6'h00, PER, 1'b0);
    do_run(2, 1'b0, 6'h3F, 4'd0, 6'h00, PER, 1'b0);
`else
    do_run(1, 1'b0, 6'h04, 4'd7, 6'h20, RUNLEN, 1'b0);
    do_run(2, 1'b0, 6'h3F, 4'd7, 6'h20, RUNLEN, 1'b0);
`endif

    // Healthy again: mask and pass must be rebuilt from scratch.
    do_run(0, 1'b1, 6'h00, 4'd7, 6'h20, RUNLEN, 1'b0);

    // Reset during the settle of pattern 3: abort, no done pulse.
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    wait_cyc(s + PER * 3 + 3);
    check("abort_idx_before", pat_idx, 3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_a", a, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_mask", fail_mask, 0);
    check("abort_idx", pat_idx, 0);
    rst = 1'b0;
    repeat (RUNLEN + 5) @(negedge clk);
    check("abort_idle", busy, 0);

    // start held high through the run, including the done cycle: exactly one run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    sb.push_back('{cyc: s + RUNLEN, pass: 1'b1, mask: 6'h00, idx: 4'd7, a: 6'h20});
    wait_cyc(s + RUNLEN + 1); // FSM has just left DONE for IDLE
    start = 1'b0;
    wait_cyc(s + RUNLEN + 4);
    check("hold_no_rerun", busy, 0);
    check("hold_done_seen", sb.size(), 0);

    // A fresh pulse after IDLE starts a new run.
    do_run(0, 1'b1, 6'h00, 4'd7, 6'h20, RUNLEN, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
